alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer_if.sv | 28 ++
 rtl/alu_mul_sequencer.sv | 115 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: start/busy/done handshake plus ALU operand bus
// between the EX-stage control side and the shift-add multiplier.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_z;

  modport master (
    output start, op_a, op_b, alu_z,
    input  busy, done, product,
    input  alu_a, alu_b, alu_op
  );

  modport slave (
    input  start, op_a, op_b, alu_z,
    output busy, done, product,
    output alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: one-bit-per-cycle shift-add multiplier on the shared ALU.
// Optional ALU_MUL_SEQUENCER_EARLY_EXIT_EN stops once the multiplier empties.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                clk,
  input logic                rst,
  alu_mul_sequencer_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  // ALU result is only folded in when the current multiplier bit is set
  assign acc_nx = mplier[0] ? bus.alu_z : acc;

`ifdef ALU_MUL_SEQUENCER_EARLY_EXIT_EN
  assign last_iter = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
  assign last_iter = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_op  = OP_AND;
    bus.product = prod;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        bus.busy   = 1'b1;
        bus.alu_a  = acc;
        bus.alu_b  = mcand;
        bus.alu_op = OP_ADD;
        if (last_iter) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      prod   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // product becomes visible together with the done pulse
          if (last_iter) begin
            prod <= acc_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed vectors against a cycle-level product model.
// Honours ALU_MUL_SEQUENCER_EARLY_EXIT_EN for the expected latencies.
module tb_alu_mul_sequencer;
  localparam int WIDTH = 32;
`ifdef ALU_MUL_SEQUENCER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_z = (bus.alu_op == 3'b010) ? bus.alu_a + bus.alu_b
                                            : bus.alu_a & bus.alu_b;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int run_len(input logic [31:0] b);
    if (!EARLY) return WIDTH;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 1;
  endfunction

  // Model: remaining RUN cycles, iterations done, pending done pulse
  int          run_left = 0;
  int          k = 0;
  bit          done_now = 1'b0;
  logic [31:0] ma = '0;
  logic [31:0] mb = '0;
  logic [31:0] mprod = '0;

  always @(posedge clk) begin
    if (rst) begin
      run_left = 0;
      k = 0;
      done_now = 1'b0;
      mprod = '0;
    end else if (done_now) begin
      done_now = 1'b0;
    end else if (run_left > 0) begin
      k++;
      run_left--;
      if (run_left == 0) begin
        done_now = 1'b1;
        mprod = ma * mb;
      end
    end else if (bus.start) begin
      ma = bus.op_a;
      mb = bus.op_b;
      k = 0;
      run_left = run_len(bus.op_b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] mask;
      logic [31:0] part;
      mask = (k == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - k));
      part = ma * (mb & mask);
      chk("busy", 64'(bus.busy), 64'(run_left > 0));
      chk("done", 64'(bus.done), 64'(done_now));
      chk("product", 64'(bus.product), 64'(mprod));
      if (run_left > 0) begin
        chk("alu_op_run", 64'(bus.alu_op), 64'(3'b010));
        chk("alu_a_run", 64'(bus.alu_a), 64'(part));
        chk("alu_b_run", 64'(bus.alu_b), 64'(32'(ma << k)));
      end else begin
        chk("alu_op_idle", 64'(bus.alu_op), 64'(3'b000));
        chk("alu_a_idle", 64'(bus.alu_a), 64'h0);
        chk("alu_b_idle", 64'(bus.alu_b), 64'h0);
      end
    end
  end

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input int exp_cyc,
                         input int inj);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.op_a = ~a;
    bus.op_b = ~b;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        seen = 1'b1;
      end else if (n == inj) begin
        #1 bus.start = 1'b1;
        bus.op_a = 32'd1;
        bus.op_b = 32'd1;
      end
    end
    chk("done_seen", 64'(seen), 64'h1);
    chk("latency", 64'(n), 64'(exp_cyc));
    chk("product_lit", 64'(bus.product), 64'(exp_p));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  initial begin
    int dn;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_product", 64'(bus.product), 64'h0);
    chk("rst_alu_op", 64'(bus.alu_op), 64'h0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'h0);
    chk("rst_alu_b", 64'(bus.alu_b), 64'h0);

    run_mul(32'd3, 32'd5, 32'd15, EARLY ? 4 : 33, 0);
    run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, EARLY ? 3 : 33, 0);
    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0, EARLY ? 18 : 33, 0);
    run_mul(32'd7, 32'd9, 32'd63, EARLY ? 5 : 33, EARLY ? 2 : 10);
    chk("no_restart_busy", 64'(bus.busy), 64'h0);
    run_mul(32'd12, 32'd1, 32'd12, EARLY ? 2 : 33, 0);
    run_mul(32'd5, 32'h8000_0000, 32'h8000_0000, 33, 0);
    run_mul(32'hDEAD_BEEF, 32'd0, 32'h0, EARLY ? 2 : 33, 0);

    // reset in the middle of 6*7
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.op_a = 32'd6;
    bus.op_b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (EARLY ? 2 : 5) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'h0);
    chk("midrst_product", 64'(bus.product), 64'h0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'h0);

    // rst and start together
    @(posedge clk);
    #1 rst = 1'b1;
    bus.start = 1'b1;
    bus.op_a = 32'd2;
    bus.op_b = 32'd3;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 64'(bus.busy), 64'h0);
    run_mul(32'd2, 32'd3, 32'd6, EARLY ? 3 : 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
